// File: rtl/dbg_pkg.sv
// Shared definitions for the CPU debug read arbiter: FSM encoding, port widths,
// and a helper that sizes requester index fields.
package dbg_pkg;

    localparam int REG_AW = 5;
    localparam int MEM_AW = 14;
    localparam int DW     = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Index width for n requesters; never below one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dbg_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo NREQ. Reports the winner as both one-hot and index.
module rr_pick
    import dbg_pkg::*;
#(
    parameter  int NREQ = 3,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    always_comb begin
        int cand;
        // NOTE: every output gets a default before the loop so no path infers a latch.
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/dbg_read_arbiter.sv
// Shares the CPU's single debug read path (register port + memory port) between
// NREQ requesters: round-robin, one access in flight, fixed RD_LAT read latency.
module dbg_read_arbiter
    import dbg_pkg::*;
#(
    parameter int                NREQ        = 3,
    parameter int                RD_LAT      = 2,
    parameter logic [REG_AW-1:0] DEF_REGADDR = 5'd10
) (
    input  logic                   clk50m,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_sel,
    input  logic [NREQ*MEM_AW-1:0] req_addr,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rvalid,
    output logic [DW-1:0]          rdata,
    output logic                   busy,
    output logic [REG_AW-1:0]      cpu_regaddr,
    output logic [MEM_AW-1:0]      cpu_memaddr,
    input  logic [DW-1:0]          cpu_regdata,
    input  logic [DW-1:0]          cpu_memdata
);

    localparam int IW = idx_w(NREQ);
    localparam int CW = 4;

    state_e            state_q,   state_d;
    logic [CW-1:0]     cnt_q,     cnt_d;
    logic [IW-1:0]     ptr_q,     ptr_d;
    logic [IW-1:0]     win_q,     win_d;
    logic [NREQ-1:0]   win_oh_q,  win_oh_d;
    logic              sel_q,     sel_d;
    logic [REG_AW-1:0] regaddr_q, regaddr_d;
    logic [MEM_AW-1:0] memaddr_q, memaddr_d;
    logic [DW-1:0]     rdata_q,   rdata_d;

    logic [NREQ-1:0]   pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_oh),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_ff @(posedge clk50m) begin
        // NOTE: non-blocking so every register updates from the same pre-edge values.
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            win_q     <= '0;
            win_oh_q  <= '0;
            sel_q     <= 1'b0;
            regaddr_q <= DEF_REGADDR;
            memaddr_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            win_oh_q  <= win_oh_d;
            sel_q     <= sel_d;
            regaddr_q <= regaddr_d;
            memaddr_q <= memaddr_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        win_oh_d  = win_oh_q;
        sel_d     = sel_q;
        regaddr_d = regaddr_q;
        memaddr_d = memaddr_q;
        rdata_d   = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    win_d    = pick_idx;
                    win_oh_d = pick_oh;
                    sel_d    = req_sel[pick_idx];
                    // Only the targeted CPU port moves; the other keeps its last address.
                    if (req_sel[pick_idx])
                        memaddr_d = req_addr[pick_idx*MEM_AW +: MEM_AW];
                    else
                        regaddr_d = req_addr[pick_idx*MEM_AW +: REG_AW];
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CW'(RD_LAT - 1)) begin
                    rdata_d = sel_q ? cpu_memdata : cpu_regdata;
                    ptr_d   = (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt    = '0;
        rvalid = '0;
        busy   = (state_q != ST_IDLE);
        if (state_q == ST_WAIT && cnt_q == '0) gnt = win_oh_q;
        if (state_q == ST_RESP) rvalid = win_oh_q;
    end

    assign rdata       = rdata_q;
    assign cpu_regaddr = regaddr_q;
    assign cpu_memaddr = memaddr_q;

endmodule

// File: tb/tb_dbg_read_arbiter.sv
// Bench for dbg_read_arbiter: three instances (RD_LAT 2, 1, 15) with private request
// lines; a scoreboard queue per instance is checked by a negedge monitor.
module tb_dbg_read_arbiter;

    localparam int NREQ = 3;
    localparam int ND   = 3;

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
    endfunction

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    logic               clk50m = 1'b0;
    logic               rst    = 1'b0;
    logic [NREQ-1:0]    req_v    [ND];
    logic [NREQ-1:0]    req_sel;
    logic [NREQ*14-1:0] req_addr;
    logic [31:0]        cpu_regdata;
    logic [31:0]        cpu_memdata;
    logic [NREQ-1:0]    gnt_v    [ND];
    logic [NREQ-1:0]    rvalid_v [ND];
    logic [31:0]        rdata_v  [ND];
    logic               busy_v   [ND];
    logic [4:0]         regaddr_v[ND];
    logic [13:0]        memaddr_v[ND];

    exp_t sb [ND][$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic rst_q    = 1'b0;
    bit   inflight [ND];
    int   gnt_cyc  [ND];

    always #5 clk50m = ~clk50m;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        dbg_read_arbiter #(
            .NREQ        (NREQ),
            .RD_LAT      ((g == 0) ? 2 : ((g == 1) ? 1 : 15)),
            .DEF_REGADDR (5'd10)
        ) u_dut (
            .clk50m      (clk50m),
            .rst         (rst),
            .req         (req_v[g]),
            .req_sel     (req_sel),
            .req_addr    (req_addr),
            .gnt         (gnt_v[g]),
            .rvalid      (rvalid_v[g]),
            .rdata       (rdata_v[g]),
            .busy        (busy_v[g]),
            .cpu_regaddr (regaddr_v[g]),
            .cpu_memaddr (memaddr_v[g]),
            .cpu_regdata (cpu_regdata),
            .cpu_memdata (cpu_memdata)
        );
    end

    always @(posedge clk50m) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: handshake shape, busy window, and scoreboard pops on rvalid.
    always @(negedge clk50m) begin
        exp_t e;
        if (cyc > 0) begin
            for (int d = 0; d < ND; d++) begin
                if (!rst_q) begin
                    sb[d].delete();
                    inflight[d] = 1'b0;
                    check($sformatf("d%0d_rst_gnt", d),    32'(gnt_v[d]),    32'd0);
                    check($sformatf("d%0d_rst_rvalid", d), 32'(rvalid_v[d]), 32'd0);
                    check($sformatf("d%0d_rst_busy", d),   32'(busy_v[d]),   32'd0);
                end else begin
                    check($sformatf("d%0d_gnt_onehot0", d),    32'($onehot0(gnt_v[d])),    32'd1);
                    check($sformatf("d%0d_rvalid_onehot0", d), 32'($onehot0(rvalid_v[d])), 32'd1);
                    check($sformatf("d%0d_busy", d), 32'(busy_v[d]),
                          32'((gnt_v[d] != '0) || inflight[d]));
                    if (gnt_v[d] != '0) begin
                        if (sb[d].size() == 0)
                            check($sformatf("d%0d_gnt_unexpected", d), 32'(gnt_v[d]), 32'd0);
                        else
                            check($sformatf("d%0d_gnt_who", d), 32'(gnt_v[d]), 32'(1) << sb[d][0].idx);
                        inflight[d] = 1'b1;
                        gnt_cyc[d]  = cyc;
                    end
                    if (rvalid_v[d] != '0) begin
                        if (sb[d].size() == 0) begin
                            check($sformatf("d%0d_rvalid_unexpected", d), 32'(rvalid_v[d]), 32'd0);
                        end else begin
                            e = sb[d].pop_front();
                            check($sformatf("d%0d_rvalid_who", d), 32'(rvalid_v[d]), 32'(1) << e.idx);
                            check($sformatf("d%0d_rdata", d), rdata_v[d], e.data);
                            check($sformatf("d%0d_rd_latency", d), 32'(cyc - gnt_cyc[d]), 32'(lat_of(d)));
                        end
                        inflight[d] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_gnt(input int d, input int r, output int tg);
        bit got;
        got = 1'b0;
        tg  = cyc;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk50m);
            if (gnt_v[d][r]) begin
                got = 1'b1;
                tg  = cyc;
            end
        end
        check($sformatf("d%0d_gnt%0d_seen", d, r), 32'(got), 32'd1);
    endtask

    task automatic wait_idle(input int d);
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 40 && !idle; k++) begin
            @(negedge clk50m);
            if (!busy_v[d]) idle = 1'b1;
        end
        check($sformatf("d%0d_idle_seen", d), 32'(idle), 32'd1);
    endtask

    task automatic do_access(input int d, input int r, input bit sel,
                             input logic [13:0] addr, input logic [31:0] data);
        int   t0, tg;
        exp_t e;
        @(negedge clk50m);
        req_sel[r]         = sel;
        req_addr[r*14 +: 14] = addr;
        cpu_regdata        = sel ? ~data : data;
        cpu_memdata        = sel ? data : ~data;
        e.idx  = r;
        e.data = data;
        sb[d].push_back(e);
        req_v[d][r] = 1'b1;
        t0 = cyc;
        wait_gnt(d, r, tg);
        req_v[d][r] = 1'b0;
        check($sformatf("d%0d_gnt_latency", d), 32'(tg - t0), 32'd1);
        wait_idle(d);
        check($sformatf("d%0d_rdata_hold", d), rdata_v[d], data);
    endtask

    task automatic check_reset_state(input int d);
        check($sformatf("d%0d_post_regaddr", d), 32'(regaddr_v[d]), 32'd10);
        check($sformatf("d%0d_post_memaddr", d), 32'(memaddr_v[d]), 32'd0);
        check($sformatf("d%0d_post_gnt", d),     32'(gnt_v[d]),     32'd0);
        check($sformatf("d%0d_post_rvalid", d),  32'(rvalid_v[d]),  32'd0);
        check($sformatf("d%0d_post_busy", d),    32'(busy_v[d]),    32'd0);
        check($sformatf("d%0d_post_rdata", d),   rdata_v[d],        32'd0);
    endtask

    task automatic t_contention();
        int          ord [4];
        logic [31:0] vals[4];
        int          tg, prev;
        exp_t        e;
        ord  = '{0, 1, 2, 0};
        vals = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
        prev = 0;
        @(negedge clk50m);
        req_sel     = '0;
        cpu_memdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            e.idx  = ord[k];
            e.data = vals[k];
            sb[0].push_back(e);
        end
        req_v[0] = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(0, ord[k], tg);
            cpu_regdata = vals[k];
            req_v[0][ord[k]] = 1'b0;
            if (k > 0) check($sformatf("rr_spacing_%0d", k), 32'(tg - prev), 32'(lat_of(0) + 2));
            prev = tg;
            if (k < 3) begin
                @(negedge clk50m);
                req_v[0][ord[k]] = 1'b1;
            end else begin
                req_v[0] = '0;
            end
        end
        wait_idle(0);
        check("rr_final_rdata", rdata_v[0], vals[3]);
    endtask

    task automatic t_reset_mid();
        int   tg;
        exp_t e;
        @(negedge clk50m);
        req_sel[0]    = 1'b0;
        req_addr[13:0] = 14'h0003;
        cpu_regdata   = 32'hBAD0_0001;
        e.idx  = 0;
        e.data = 32'hBAD0_0001;
        sb[0].push_back(e);
        req_v[0][0] = 1'b1;
        wait_gnt(0, 0, tg);
        req_v[0][0] = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk50m);
        rst = 1'b1;
        repeat (6) @(negedge clk50m);
        for (int d = 0; d < ND; d++) check_reset_state(d);
    endtask

    task automatic t_wrap(input int d);
        int          tg;
        exp_t        e;
        logic [31:0] v;
        do_access(d, NREQ - 1, 1'b0, 14'h3FE7, 32'hC0DE_0000 + 32'(d));
        check($sformatf("d%0d_regaddr_low5", d), 32'(regaddr_v[d]), 32'h07);
        v = 32'h5A5A_0000 + 32'(d);
        @(negedge clk50m);
        req_sel     = '0;
        cpu_regdata = v;
        e.idx  = 0;
        e.data = v;
        sb[d].push_back(e);
        req_v[d] = 3'b011;
        wait_gnt(d, 0, tg);
        req_v[d] = '0;
        wait_idle(d);
        check($sformatf("d%0d_wrap_rdata", d), rdata_v[d], v);
    endtask

    initial begin
        for (int d = 0; d < ND; d++) req_v[d] = '0;
        req_sel     = '0;
        req_addr    = '0;
        cpu_regdata = '0;
        cpu_memdata = '0;
        rst         = 1'b0;

        // T1: reset state
        repeat (3) @(negedge clk50m);
        for (int d = 0; d < ND; d++) check_reset_state(d);
        rst = 1'b1;
        @(negedge clk50m);

        // T2: register read by requester 1
        do_access(0, 1, 1'b0, 14'h0005, 32'hDEAD_BEEF);
        check("t2_regaddr", 32'(regaddr_v[0]), 32'd5);
        check("t2_memaddr", 32'(memaddr_v[0]), 32'd0);

        // T3: memory read by requester 2
        do_access(0, 2, 1'b1, 14'h1234, 32'h0000_0ABC);
        check("t3_memaddr", 32'(memaddr_v[0]), 32'h1234);
        check("t3_regaddr", 32'(regaddr_v[0]), 32'd5);

        // T4: contention, round-robin order and spacing
        t_contention();

        // T5: reset while an access is in WAIT
        t_reset_mid();

        // T6: latency extremes, pointer wrap, register address truncation
        t_wrap(1);
        t_wrap(2);

        repeat (4) @(negedge clk50m);
        for (int d = 0; d < ND; d++)
            check($sformatf("d%0d_scoreboard_empty", d), 32'(sb[d].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
